// File: rtl/axis_result_capture.sv
// axis_result_capture: captures an AXI-Stream frame of a configured length
// into a word-addressed result RAM. It keeps a beat count and a wrap-around
// checksum, and flags a frame whose tlast does not land on the last beat.
module axis_result_capture #(
    parameter int pADDR_WIDTH = 12,
    parameter int pDATA_WIDTH = 32
) (
    input  logic                   axis_clk,
    input  logic                   axis_rst_n,
    input  logic                   start,
    input  logic [31:0]            cfg_len,
    input  logic                   s_tvalid,
    input  logic [pDATA_WIDTH-1:0] s_tdata,
    input  logic                   s_tlast,
    output logic                   s_tready,
    output logic [3:0]             ram_WE,
    output logic                   ram_EN,
    output logic [pDATA_WIDTH-1:0] ram_Di,
    output logic [pADDR_WIDTH-1:0] ram_A,
    output logic                   busy,
    output logic                   done,
    output logic                   err_early_last,
    output logic                   err_missing_last,
    output logic [31:0]            count,
    output logic [31:0]            checksum
);

    typedef enum logic [1:0] {IDLE, CAPTURE, DONE} state_t;

    state_t      state, state_nxt;
    logic [31:0] len_q;
    logic [31:0] count_inc;
    logic [31:0] data_ext;
    logic        start_ok;
    logic        accept;
    logic        last_beat;

    // start only counts outside CAPTURE; a beat lands only while CAPTURE
    assign start_ok  = start && (state != CAPTURE);
    assign accept    = s_tvalid && (state == CAPTURE);
    assign count_inc = count + 32'd1;
    assign last_beat = (count_inc == len_q);

    // ready, busy and done are pure decodes of the registered state
    assign s_tready = (state == CAPTURE);
    assign busy     = (state == CAPTURE);
    assign done     = (state == DONE);

    // sign-extend narrow samples so the checksum is a true signed sum
    if (pDATA_WIDTH >= 32) begin : g_ext_wide
        assign data_ext = s_tdata[31:0];
    end else begin : g_ext_narrow
        assign data_ext = 32'(signed'(s_tdata));
    end

    // state register
    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) state <= IDLE;
        else             state <= state_nxt;
    end

    // next-state: a zero-length start goes straight to DONE
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: begin
                if (start) state_nxt = (cfg_len != 32'd0) ? CAPTURE : DONE;
            end
            CAPTURE: begin
                if (accept && (s_tlast || last_beat)) state_nxt = DONE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // counters, error flags and the one-cycle-delayed RAM write port
    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            len_q            <= '0;
            count            <= '0;
            checksum         <= '0;
            err_early_last   <= 1'b0;
            err_missing_last <= 1'b0;
            ram_EN           <= 1'b0;
            ram_WE           <= 4'h0;
            ram_Di           <= '0;
            ram_A            <= '0;
        end else begin
            ram_EN <= 1'b0;
            ram_WE <= 4'h0;
            if (start_ok) begin
                if (cfg_len != 32'd0) len_q <= cfg_len;
                count            <= '0;
                checksum         <= '0;
                err_early_last   <= 1'b0;
                err_missing_last <= 1'b0;
            end else if (accept) begin
                count    <= count_inc;
                checksum <= checksum + data_ext;
                ram_EN   <= 1'b1;
                ram_WE   <= 4'hF;
                ram_Di   <= s_tdata;
                // byte address of the beat; upper bits drop so it wraps silently
                ram_A    <= pADDR_WIDTH'({count[29:0], 2'b00});
                if (s_tlast && (count_inc < len_q)) err_early_last   <= 1'b1;
                if (last_beat && !s_tlast)          err_missing_last <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_axis_result_capture.sv
// Directed bench for axis_result_capture: a vector table for the short
// frame cases plus hand sequences for long, wrapping and reset captures.
module tb_axis_result_capture;

    logic        axis_clk = 1'b0;
    logic        axis_rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] cfg_len = '0;
    logic        s_tvalid = 1'b0;
    logic [31:0] s_tdata = '0;
    logic        s_tlast = 1'b0;
    logic        s_tready;
    logic [3:0]  ram_WE;
    logic        ram_EN;
    logic [31:0] ram_Di;
    logic [11:0] ram_A;
    logic        busy, done, err_early_last, err_missing_last;
    logic [31:0] count, checksum;

    axis_result_capture #(.pADDR_WIDTH(12), .pDATA_WIDTH(32)) dut (
        .axis_clk(axis_clk), .axis_rst_n(axis_rst_n), .start(start),
        .cfg_len(cfg_len), .s_tvalid(s_tvalid), .s_tdata(s_tdata),
        .s_tlast(s_tlast), .s_tready(s_tready), .ram_WE(ram_WE),
        .ram_EN(ram_EN), .ram_Di(ram_Di), .ram_A(ram_A), .busy(busy),
        .done(done), .err_early_last(err_early_last),
        .err_missing_last(err_missing_last), .count(count),
        .checksum(checksum)
    );

    always #5 axis_clk = ~axis_clk;

    typedef struct {
        logic        st;
        logic [31:0] len;
        logic        vld;
        logic [31:0] data;
        logic        last;
        logic        rdy, bsy, dn, ee, em, en;
        logic [11:0] a;
        logic [31:0] di, cnt, chk;
    } vec_t;

    typedef struct {
        logic [11:0] a;
        logic [31:0] d;
        logic [3:0]  we;
    } wr_t;

    vec_t        vt[15];
    wr_t         wq[$];
    logic [31:0] eq[$];
    int          tests = 0;
    int          fails = 0;

    // every RAM strobe is held for exactly one cycle, so one sample per cycle
    always @(negedge axis_clk) begin
        if (ram_EN === 1'b1) wq.push_back('{ram_A, ram_Di, ram_WE});
    end

    function automatic logic [127:0] pack(
        input logic rdy, bsy, dn, ee, em, en, input logic [3:0] we,
        input logic [11:0] a, input logic [31:0] di, cnt, chk);
        return {10'b0, rdy, bsy, dn, ee, em, en, we, a, di, cnt, chk};
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge axis_clk);
        #1;
    endtask

    // drive one full frame of len beats (tlast on the final one), gap idle
    // cycles between beats, then check status and every logged write
    task automatic run_seq(input string name, input int len, input int gap);
        logic [31:0] sum;
        int          bad;
        sum = 0;
        start = 1'b1; cfg_len = len;
        step();
        start = 1'b0; cfg_len = 0;
        wq.delete(); eq.delete();
        for (int i = 0; i < len; i++) begin
            s_tvalid = 1'b1;
            s_tdata  = $urandom;
            s_tlast  = (i == len - 1);
            eq.push_back(s_tdata);
            sum += s_tdata;
            step();
            s_tvalid = 1'b0; s_tlast = 1'b0;
            if (i == len - 1) check({name, "_done_with_last_wr"}, {126'b0, done, ram_EN}, 128'h3);
            repeat (gap) step();
        end
        step();
        check({name, "_status"}, {64'b0, 27'b0, done, busy, s_tready, err_early_last, err_missing_last, count},
              {64'b0, 27'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'(len)});
        check({name, "_checksum"}, {96'b0, checksum}, {96'b0, sum});
        check({name, "_wr_count"}, 128'(wq.size()), 128'(len));
        bad = 0;
        for (int i = 0; i < wq.size() && i < len; i++) begin
            if (wq[i].a !== 12'((i * 4) % 4096) || wq[i].d !== eq[i] || wq[i].we !== 4'hF) bad++;
        end
        check({name, "_wr_contents_bad"}, 128'(bad), 128'd0);
    endtask

    initial begin
        // st len vld data last | rdy bsy dn ee em en a di cnt chk
        vt[0]  = '{0, 0, 1, 99, 1,           0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        vt[1]  = '{1, 4, 0, 0, 0,            1, 1, 0, 0, 0, 0, 0, 0, 0, 0};
        vt[2]  = '{0, 0, 1, 5, 0,            1, 1, 0, 0, 0, 1, 0, 5, 1, 5};
        vt[3]  = '{0, 0, 1, 32'hFFFFFFFD, 1, 0, 0, 1, 1, 0, 1, 4, 32'hFFFFFFFD, 2, 2};
        vt[4]  = '{0, 0, 1, 7, 0,            0, 0, 1, 1, 0, 0, 0, 0, 2, 2};
        vt[5]  = '{1, 3, 0, 0, 0,            1, 1, 0, 0, 0, 0, 0, 0, 0, 0};
        vt[6]  = '{0, 0, 1, 10, 0,           1, 1, 0, 0, 0, 1, 0, 10, 1, 10};
        vt[7]  = '{0, 0, 1, 20, 0,           1, 1, 0, 0, 0, 1, 4, 20, 2, 30};
        vt[8]  = '{0, 0, 1, 30, 0,           0, 0, 1, 0, 1, 1, 8, 30, 3, 60};
        vt[9]  = '{1, 0, 0, 0, 0,            0, 0, 1, 0, 0, 0, 0, 0, 0, 0};
        vt[10] = '{1, 2, 0, 0, 0,            1, 1, 0, 0, 0, 0, 0, 0, 0, 0};
        vt[11] = '{0, 0, 0, 77, 1,           1, 1, 0, 0, 0, 0, 0, 0, 0, 0};
        vt[12] = '{0, 0, 1, 1, 0,            1, 1, 0, 0, 0, 1, 0, 1, 1, 1};
        vt[13] = '{1, 7, 1, 2, 1,            0, 0, 1, 0, 0, 1, 4, 2, 2, 3};
        vt[14] = '{0, 0, 1, 9, 1,            0, 0, 1, 0, 0, 0, 0, 0, 2, 3};

        // reset state
        #1;
        check("reset_state", pack(s_tready, busy, done, err_early_last, err_missing_last, ram_EN, ram_WE,
              ram_A, ram_Di, count, checksum), 128'd0);
        step();
        axis_rst_n = 1'b1;
        step();

        // short frames: IDLE ignores beats, early tlast, missing tlast,
        // zero length, start ignored mid-capture, DONE stalls further beats
        foreach (vt[i]) begin
            start = vt[i].st; cfg_len = vt[i].len; s_tvalid = vt[i].vld;
            s_tdata = vt[i].data; s_tlast = vt[i].last;
            step();
            check($sformatf("vec%0d", i),
                  pack(s_tready, busy, done, err_early_last, err_missing_last, ram_EN, ram_WE,
                       vt[i].en ? ram_A : 12'd0, vt[i].en ? ram_Di : 32'd0, count, checksum),
                  pack(vt[i].rdy, vt[i].bsy, vt[i].dn, vt[i].ee, vt[i].em, vt[i].en,
                       vt[i].en ? 4'hF : 4'h0, vt[i].a, vt[i].di, vt[i].cnt, vt[i].chk));
        end
        start = 1'b0; s_tvalid = 1'b0; s_tlast = 1'b0;
        step();

        // long back-to-back frame, then a gapped frame that wraps ram_A
        run_seq("len600", 600, 0);
        run_seq("len1030_gap", 1030, 2);
        check("wrap_beat1024_addr", 128'(wq.size() > 1024 ? wq[1024].a : 12'hFFF), 128'd0);

        // reset asserted right after the 10th beat of a 20-beat frame
        start = 1'b1; cfg_len = 20;
        step();
        start = 1'b0;
        wq.delete();
        for (int i = 0; i < 10; i++) begin
            s_tvalid = 1'b1; s_tdata = 32'(i + 1);
            step();
        end
        axis_rst_n = 1'b0;
        #1;
        check("midreset_outputs", pack(s_tready, busy, done, err_early_last, err_missing_last, ram_EN, ram_WE,
              ram_A, ram_Di, count, checksum), 128'd0);
        repeat (2) step();
        axis_rst_n = 1'b1;
        repeat (3) step();
        check("post_reset_idle", {94'b0, s_tready, busy, count}, 128'd0);
        check("post_reset_wr_count", 128'(wq.size()), 128'd9);
        s_tvalid = 1'b0;

        // capture restarts after reset only with a new start
        start = 1'b1; cfg_len = 1;
        step();
        start = 1'b0; s_tvalid = 1'b1; s_tdata = 32'd42; s_tlast = 1'b1;
        step();
        s_tvalid = 1'b0; s_tlast = 1'b0;
        check("restart_after_reset", {63'b0, done, ram_EN, ram_Di, count, checksum},
              {63'b0, 1'b1, 1'b1, 32'd42, 32'd1, 32'd42});

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/axis_result_capture.md
AXIS_RESULT_CAPTURE -- requirements
Module: axis_result_capture

Interface
REQ-001 SHALL have parameter pADDR_WIDTH, default 12, the byte-address width of the result RAM port.
REQ-002 SHALL have parameter pDATA_WIDTH, default 32, the width of stream data and RAM data.
REQ-003 SHALL have port axis_clk  input  1  the single clock; all logic is rising-edge.
REQ-004 SHALL have port axis_rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  single-cycle pulse that arms a capture.
REQ-006 SHALL have port cfg_len  input  32  number of beats expected; sampled only on an accepted start.
REQ-007 SHALL have port s_tvalid  input  1  AXI-Stream slave valid, from the FIR sm_tvalid.
REQ-008 SHALL have port s_tdata  input  pDATA_WIDTH  signed stream sample.
REQ-009 SHALL have port s_tlast  input  1  end-of-frame marker.
REQ-010 SHALL have port s_tready  output  1  AXI-Stream slave ready.
REQ-011 SHALL have port ram_WE  output  4  byte write enables, bram11-style.
REQ-012 SHALL have port ram_EN  output  1  RAM enable.
REQ-013 SHALL have port ram_Di  output  pDATA_WIDTH  RAM write data.
REQ-014 SHALL have port ram_A  output  pADDR_WIDTH  RAM byte address.
REQ-015 SHALL have port busy  output  1  high while in CAPTURE.
REQ-016 SHALL have port done  output  1  high while in DONE.
REQ-017 SHALL have port err_early_last  output  1  tlast arrived before cfg_len beats.
REQ-018 SHALL have port err_missing_last  output  1  the cfg_len-th beat arrived without tlast.
REQ-019 SHALL have port count  output  32  beats accepted in the current or last capture.
REQ-020 SHALL have port checksum  output  32  wrap-around sum of accepted s_tdata, taken modulo 2^32.

Function
REQ-021 SHALL implement three states: IDLE, CAPTURE and DONE.
REQ-022 SHALL, in IDLE or DONE on start=1 with cfg_len!=0, latch cfg_len, clear count, checksum and both error flags, and enter CAPTURE on the next edge.
REQ-023 SHALL, in IDLE or DONE on start=1 with cfg_len==0, clear count, checksum and both error flags, and enter DONE with no RAM write.
REQ-024 SHALL ignore start while in CAPTURE.
REQ-025 SHALL drive s_tready=1 exactly when state==CAPTURE, combinationally from state only and never from s_tvalid.
REQ-026 SHALL treat a beat as accepted when s_tvalid and s_tready are both 1 on a rising edge.
REQ-027 SHALL, on each accepted beat, increment count by 1 and add s_tdata to checksum in that same edge.
REQ-028 SHALL, for each accepted beat, drive ram_EN=1, ram_WE=4'hF, ram_Di=beat data and ram_A=(beat index*4) mod 2^pADDR_WIDTH in the cycle after acceptance (registered, 1-cycle latency).
REQ-029 SHALL drive ram_EN=0 and ram_WE=0 in every other cycle.
REQ-030 SHALL let ram_A wrap to 0 after 1024 words with pADDR_WIDTH=12; the wrap is silent and count keeps incrementing.
REQ-031 SHALL go to DONE with no error when the accepted beat has count+1==len and s_tlast=1.
REQ-032 SHALL go to DONE and set err_early_last when the accepted beat has s_tlast=1 and count+1<len.
REQ-033 SHALL go to DONE and set err_missing_last when the accepted beat has count+1==len and s_tlast=0.
REQ-034 SHALL make done and busy registered state decodes, so that done rises in the same cycle as the final RAM write strobe.
REQ-035 SHALL hold done, count, checksum and the error flags stable in DONE until the next accepted start.
REQ-036 SHALL leave s_tready low in DONE; further beats stall upstream and are not written.

Reset
REQ-037 SHALL, on axis_rst_n=0 in any state, including mid-capture, immediately force state=IDLE, s_tready=0, ram_EN=0, ram_WE=0, ram_Di=0, ram_A=0, busy=0, done=0, both error flags=0, count=0 and checksum=0.
REQ-038 SHALL, on axis_rst_n=0, cancel any pending registered RAM write with no write issued.
REQ-039 SHALL require a new start after reset release before any capture.

Verification
REQ-040 SHALL be checked with: start, cfg_len=600, 600 beats with tlast on beat 599, s_tvalid always high -> 600 writes at A=0..2396 step 4, count=600, correct checksum, done=1, no errors.
REQ-041 SHALL be checked with: cfg_len=4, data 5,-3,7,1, tlast on beat 1 -> 2 writes, count=2, checksum=2, err_early_last=1, s_tready=0 afterwards.
REQ-042 SHALL be checked with: cfg_len=3, tlast never asserted -> 3 writes, count=3, err_missing_last=1, done=1.
REQ-043 SHALL be checked with: cfg_len=1030 and gapped s_tvalid (1 beat every 3 cycles) -> beat 1024 written at A=0, count=1030, no errors.
REQ-044 SHALL be checked with: axis_rst_n pulsed low after beat 10 of 20 -> all outputs zero within the reset cycle, no write for the pending beat, s_tready=0 until the next start.
REQ-045 SHALL be checked with: start with cfg_len=0 -> done=1 next cycle, count=0, no RAM write; then start with cfg_len=2 -> normal capture restarts.
